// File: rtl/cylindrical_to_cartesian.sv
// Polar voxel address (theta, radius, z) to grid coordinates around (RANGE/2, RANGE/2).
// Three registered stages: sine ROM read, rounded magnitude, centre offset with saturation.

module xilinx_single_port_ram_read_first #(
    parameter int RAM_WIDTH = 11,
    parameter int RAM_DEPTH = 257,
    parameter int SIN_FRAC  = 10
) (
    input  logic                         clka,
    input  logic                         ena,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    output logic [RAM_WIDTH-1:0]         douta
);
    localparam int     QTR   = RAM_DEPTH - 1;
    localparam longint ONE   = 64'sd1 <<< 30;
    localparam longint PI_FX = 64'sd3373259426;

    // Quarter-wave sine by Taylor series in 2.30 fixed point, rounded to SIN_FRAC fraction bits.
    function automatic logic [RAM_WIDTH-1:0] sine_entry(input int idx);
        longint x, x2, term, acc;
        x    = (PI_FX * longint'(idx)) / (longint'(2) * longint'(QTR));
        x2   = (x * x) / ONE;
        term = x;
        acc  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) / ONE) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return RAM_WIDTH'((acc * (longint'(1) <<< SIN_FRAC) + (ONE >>> 1)) / ONE);
    endfunction

    logic [RAM_WIDTH-1:0] rom_w [RAM_DEPTH];

    for (genvar g = 0; g < RAM_DEPTH; g++) begin : g_rom
        assign rom_w[g] = sine_entry(g);
    end

    always_ff @(posedge clka) begin
        if (ena) douta <= rom_w[addra];
    end
endmodule

module cylindrical_to_cartesian #(
    parameter int RANGE                 = 64,
    parameter int ROTATIONAL_RESOLUTION = 1024,
    parameter int SIN_FRAC              = 10
) (
    input  logic                                     clk_in,
    input  logic                                     rst_n_in,
    input  logic [$clog2(ROTATIONAL_RESOLUTION)-1:0] theta_in,
    input  logic [$clog2(RANGE)-1:0]                 radius_in,
    input  logic [$clog2(RANGE)-1:0]                 z_in,
    input  logic                                     new_data,
    output logic                                     in_ready,
    output logic [$clog2(RANGE)-1:0]                 x_out,
    output logic [$clog2(RANGE)-1:0]                 y_out,
    output logic [$clog2(RANGE)-1:0]                 z_out,
    output logic                                     data_ready,
    input  logic                                     out_ready
);
    localparam int TW   = $clog2(ROTATIONAL_RESOLUTION);
    localparam int CW   = $clog2(RANGE);
    localparam int Q    = ROTATIONAL_RESOLUTION / 4;
    localparam int PW   = TW - 2;
    localparam int AW   = PW + 1;
    localparam int TBW  = SIN_FRAC + 1;
    localparam int PRW  = CW + TBW + 1;
    localparam int SW   = CW + 2;
    localparam int HALF = 1 << (SIN_FRAC - 1);
    localparam logic signed [SW-1:0] CENTRE = SW'(RANGE / 2);
    localparam logic signed [SW-1:0] TOP    = SW'(RANGE - 1);

    logic advance;
    assign in_ready = !(data_ready && !out_ready);
    assign advance  = in_ready;

    // Quadrant fold: odd quadrants swap which table index feeds sin and cos.
    logic [1:0]    quad;
    logic [AW-1:0] p_ext, q_minus_p, sin_addr, cos_addr;
    assign quad      = theta_in[TW-1 -: 2];
    assign p_ext     = {1'b0, theta_in[PW-1:0]};
    assign q_minus_p = AW'(Q) - p_ext;
    assign sin_addr  = quad[0] ? q_minus_p : p_ext;
    assign cos_addr  = quad[0] ? p_ext : q_minus_p;

    logic [TBW-1:0] sin_mag, cos_mag;

    xilinx_single_port_ram_read_first #(.RAM_WIDTH(TBW), .RAM_DEPTH(Q + 1), .SIN_FRAC(SIN_FRAC))
        u_rom_sin (.clka(clk_in), .ena(advance), .addra(sin_addr), .douta(sin_mag));

    xilinx_single_port_ram_read_first #(.RAM_WIDTH(TBW), .RAM_DEPTH(Q + 1), .SIN_FRAC(SIN_FRAC))
        u_rom_cos (.clka(clk_in), .ena(advance), .addra(cos_addr), .douta(cos_mag));

    logic          v1_q, sin_neg1_q, cos_neg1_q;
    logic [CW-1:0] r1_q, z1_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v1_q       <= 1'b0;
            sin_neg1_q <= 1'b0;
            cos_neg1_q <= 1'b0;
            r1_q       <= '0;
            z1_q       <= '0;
        end else if (advance) begin
            v1_q       <= new_data;
            sin_neg1_q <= quad[1];
            cos_neg1_q <= quad[1] ^ quad[0];
            r1_q       <= radius_in;
            z1_q       <= z_in;
        end
    end

    logic [PRW-1:0] prod_x, prod_y;
    logic [CW-1:0]  mag_x_d, mag_y_d;
    assign prod_x  = PRW'(r1_q) * PRW'(cos_mag) + PRW'(HALF);
    assign prod_y  = PRW'(r1_q) * PRW'(sin_mag) + PRW'(HALF);
    assign mag_x_d = CW'(prod_x >> SIN_FRAC);
    assign mag_y_d = CW'(prod_y >> SIN_FRAC);

    logic          v2_q, x_neg2_q, y_neg2_q;
    logic [CW-1:0] mag_x2_q, mag_y2_q, z2_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v2_q     <= 1'b0;
            x_neg2_q <= 1'b0;
            y_neg2_q <= 1'b0;
            mag_x2_q <= '0;
            mag_y2_q <= '0;
            z2_q     <= '0;
        end else if (advance) begin
            v2_q     <= v1_q;
            x_neg2_q <= cos_neg1_q;
            y_neg2_q <= sin_neg1_q;
            mag_x2_q <= mag_x_d;
            mag_y2_q <= mag_y_d;
            z2_q     <= z1_q;
        end
    end

    function automatic logic [CW-1:0] saturate(input logic signed [SW-1:0] v);
        if (v[SW-1]) return '0;
        if (v > TOP) return CW'(RANGE - 1);
        return v[CW-1:0];
    endfunction

    logic signed [SW-1:0] off_x, off_y, x_s, y_s;
    assign off_x = $signed({2'b00, mag_x2_q});
    assign off_y = $signed({2'b00, mag_y2_q});
    assign x_s   = x_neg2_q ? CENTRE - off_x : CENTRE + off_x;
    assign y_s   = y_neg2_q ? CENTRE - off_y : CENTRE + off_y;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_ready <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            z_out      <= '0;
        end else if (advance) begin
            data_ready <= v2_q;
            x_out      <= saturate(x_s);
            y_out      <= saturate(y_s);
            z_out      <= z2_q;
        end
    end
endmodule
